// File: rtl/red_pitaya_iq_dec_pkg.sv
// Shared definitions for the IQ decimator: FSM encoding, FIFO entry layout,
// register map and control/status bit positions.
package red_pitaya_iq_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_RUN       = 2'd2
    } dec_state_e;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] i;
    } iq_entry_t;

    localparam logic [15:0] ADDR_CTRL   = 16'h0100;
    localparam logic [15:0] ADDR_DEC    = 16'h0104;
    localparam logic [15:0] ADDR_NCAP   = 16'h0108;
    localparam logic [15:0] ADDR_LEVEL  = 16'h010C;
    localparam logic [15:0] ADDR_DATA   = 16'h0110;
    localparam logic [15:0] ADDR_CAPT   = 16'h0114;
    localparam logic [15:0] ADDR_TS     = 16'h0118;
    localparam logic [15:0] ADDR_P_SIG  = 16'h0200;
    localparam logic [15:0] ADDR_P_DEC  = 16'h0204;
    localparam logic [15:0] ADDR_P_FIFO = 16'h0208;

    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_TRIG_EXT = 1;
    localparam int unsigned CTRL_ABORT    = 2;

    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_TRIG_EXT  = 1;
    localparam int unsigned STAT_EMPTY     = 2;
    localparam int unsigned STAT_FULL      = 3;
    localparam int unsigned STAT_OVF       = 4;
    localparam int unsigned STAT_STATE_LSB = 8;

    localparam int unsigned DEC_FIELD_W = 5;

endpackage

// File: rtl/red_pitaya_iq_dec_fifo.sv
// Synchronous FIFO for averaged IQ entries; a push into a full FIFO only
// succeeds when a pop happens in the same cycle.
module red_pitaya_iq_dec_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 10
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head_c,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt_n;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head_c  = mem[rd_ptr];

    always_comb begin
        cnt_n = level;
        if (flush) begin
            cnt_n = '0;
        end else if (do_push && !do_pop) begin
            cnt_n = level + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            cnt_n = level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            level <= cnt_n;
            full  <= (cnt_n == (AW+1)'(DEPTH));
            empty <= (cnt_n == '0);
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/red_pitaya_iq_decimator_block.sv
// Box-car decimator for the IQ block quadratures with FIFO readout over the PS bus.
// Define IQ_DEC_TIMESTAMP_EN to store a 32b push timestamp with every entry.
module red_pitaya_iq_decimator_block
    import red_pitaya_iq_dec_pkg::*;
#(
    parameter int unsigned SIGNALBITS = 14,
    parameter int unsigned DECMAX     = 16,
    parameter int unsigned FIFOSZ     = 10,
    parameter int unsigned CNTBITS    = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [SIGNALBITS-1:0] i_i,
    input  logic [SIGNALBITS-1:0] q_i,
    input  logic                  trig_i,
    output logic                  busy_o,
    input  logic [15:0]           addr,
    input  logic                  wen,
    input  logic                  ren,
    output logic                  ack,
    output logic [31:0]           rdata,
    input  logic [31:0]           wdata
);

    localparam int unsigned ACCW = SIGNALBITS + DECMAX;
    localparam int unsigned DECW = DEC_FIELD_W;
    localparam int unsigned LVLW = FIFOSZ + 1;
`ifdef IQ_DEC_TIMESTAMP_EN
    localparam int unsigned FIFO_W = 64;
`else
    localparam int unsigned FIFO_W = 32;
`endif

    dec_state_e          state, state_n;
    logic                push_c;
    logic [DECW-1:0]     dec_reg, dec_run;
    logic [CNTBITS-1:0]  ncap_reg, ncap_run;
    logic [CNTBITS-1:0]  captured, capt_inc;
    logic                trig_ext, trig_q, trig_rise;
    logic                overflow;
    logic signed [ACCW-1:0] acc_i, acc_q, sum_i, sum_q;
    logic [DECMAX-1:0]   cnt;
    logic [DECMAX:0]     blk_len;
    logic                blk_last;
    logic                wr_ctrl, start_req, abort_req, start_go, rd_pop;
    iq_entry_t           push_entry;
    logic [FIFO_W-1:0]   fifo_wdata, fifo_head_c;
    logic                fifo_full, fifo_empty;
    logic [LVLW-1:0]     fifo_level;
    logic [31:0]         rd_mux, status;

    assign wr_ctrl   = wen && (addr == ADDR_CTRL);
    assign start_req = wr_ctrl && wdata[CTRL_START];
    assign abort_req = wr_ctrl && wdata[CTRL_ABORT];
    assign start_go  = start_req && !abort_req && (state == ST_IDLE);
    assign rd_pop    = ren && (addr == ADDR_DATA) && !fifo_empty;
    assign trig_rise = trig_i & ~trig_q;

    assign blk_len  = (DECMAX+1)'(1) << dec_run;
    assign blk_last = (cnt == DECMAX'(blk_len - (DECMAX+1)'(1)));
    assign capt_inc = captured + CNTBITS'(1);

    // Block sum includes the current sample so consecutive blocks have no gap.
    assign sum_i = acc_i + $signed({{DECMAX{i_i[SIGNALBITS-1]}}, i_i});
    assign sum_q = acc_q + $signed({{DECMAX{q_i[SIGNALBITS-1]}}, q_i});
    assign push_entry.i = 16'(sum_i >>> dec_run);
    assign push_entry.q = 16'(sum_q >>> dec_run);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= ST_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        push_c  = 1'b0;
        if (abort_req) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req)
                        state_n = wdata[CTRL_TRIG_EXT] ? ST_WAIT_TRIG : ST_RUN;
                end
                ST_WAIT_TRIG: begin
                    if (trig_rise) state_n = ST_RUN;
                end
                ST_RUN: begin
                    push_c = blk_last;
                    if (blk_last && (ncap_run != '0) && (capt_inc == ncap_run))
                        state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Accumulator, block counter and capture bookkeeping.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc_i    <= '0;
            acc_q    <= '0;
            cnt      <= '0;
            captured <= '0;
            overflow <= 1'b0;
            dec_run  <= '0;
            ncap_run <= '0;
        end else if (start_go) begin
            acc_i    <= '0;
            acc_q    <= '0;
            cnt      <= '0;
            captured <= '0;
            overflow <= 1'b0;
            dec_run  <= dec_reg;
            ncap_run <= ncap_reg;
        end else if (push_c) begin
            acc_i    <= '0;
            acc_q    <= '0;
            cnt      <= '0;
            captured <= capt_inc;
            if (fifo_full && !rd_pop) overflow <= 1'b1;
        end else if (state == ST_RUN) begin
            acc_i <= sum_i;
            acc_q <= sum_q;
            cnt   <= cnt + DECMAX'(1);
        end
    end

`ifdef IQ_DEC_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)       ts_cnt <= '0;
        else if (start_go) ts_cnt <= '0;
        else               ts_cnt <= ts_cnt + 32'd1;
    end

    assign fifo_wdata = {ts_cnt, push_entry};
`else
    assign fifo_wdata = push_entry;
`endif

    red_pitaya_iq_dec_fifo #(
        .WIDTH (FIFO_W),
        .AW    (FIFOSZ)
    ) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .flush  (start_go),
        .push   (push_c),
        .pop    (rd_pop),
        .wdata  (fifo_wdata),
        .head_c (fifo_head_c),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    always_comb begin
        status = '0;
        rd_mux = '0;
        status[STAT_STATE_LSB +: 2] = state;
        status[STAT_OVF]      = overflow;
        status[STAT_FULL]     = fifo_full;
        status[STAT_EMPTY]    = fifo_empty;
        status[STAT_TRIG_EXT] = trig_ext;
        status[STAT_BUSY]     = busy_o;
        case (addr)
            ADDR_CTRL:   rd_mux = status;
            ADDR_DEC:    rd_mux = 32'(dec_reg);
            ADDR_NCAP:   rd_mux = 32'(ncap_reg);
            ADDR_LEVEL:  rd_mux = 32'(fifo_level);
            ADDR_DATA:   rd_mux = fifo_empty ? '0 : fifo_head_c[31:0];
            ADDR_CAPT:   rd_mux = 32'(captured);
`ifdef IQ_DEC_TIMESTAMP_EN
            ADDR_TS:     rd_mux = fifo_empty ? '0 : fifo_head_c[63:32];
`endif
            ADDR_P_SIG:  rd_mux = 32'(SIGNALBITS);
            ADDR_P_DEC:  rd_mux = 32'(DECMAX);
            ADDR_P_FIFO: rd_mux = 32'(FIFOSZ);
            default:     rd_mux = '0;
        endcase
    end

    // Bus side: config registers, ack/rdata, trigger sampling and busy flag.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ack      <= 1'b0;
            rdata    <= '0;
            dec_reg  <= '0;
            ncap_reg <= '0;
            trig_ext <= 1'b0;
            trig_q   <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            ack    <= wen | ren;
            trig_q <= trig_i;
            busy_o <= (state_n != ST_IDLE);
            if (ren) rdata <= rd_mux;
            if (wr_ctrl) trig_ext <= wdata[CTRL_TRIG_EXT];
            if (wen && (addr == ADDR_DEC))
                dec_reg <= (wdata > 32'(DECMAX)) ? DECW'(DECMAX) : DECW'(wdata);
            if (wen && (addr == ADDR_NCAP))
                ncap_reg <= CNTBITS'(wdata);
        end
    end

endmodule

// File: tb/tb_red_pitaya_iq_decimator_block.sv
// Scoreboard bench for red_pitaya_iq_decimator_block: expected FIFO entries are
// queued at start and compared as the bus drains the FIFO.
module tb_red_pitaya_iq_decimator_block;

    logic        clk = 1'b0;
    logic        rstn;
    logic [13:0] i_sig, q_sig;
    logic        trig;
    logic        busy;
    logic [15:0] addr;
    logic        wen, ren, ack;
    logic [31:0] rdata, wdata;

    int unsigned gen_cnt = 0;
    int unsigned last_gen = 0;
    int          mode;
    logic [13:0] c_i, c_q;
    logic [31:0] exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    red_pitaya_iq_decimator_block dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .i_i    (i_sig),
        .q_i    (q_sig),
        .trig_i (trig),
        .busy_o (busy),
        .addr   (addr),
        .wen    (wen),
        .ren    (ren),
        .ack    (ack),
        .rdata  (rdata),
        .wdata  (wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) gen_cnt <= gen_cnt + 1;

    // Sample sources: constant, ramp 0..7, alternating pair, long ramp.
    always_comb begin
        case (mode)
            0: begin i_sig = c_i; q_sig = c_q; end
            1: begin i_sig = 14'(gen_cnt % 8); q_sig = 14'(0 - (gen_cnt % 8)); end
            2: begin i_sig = gen_cnt[0] ? -14'sd4 : -14'sd3; q_sig = gen_cnt[0] ? 14'sd4 : 14'sd3; end
            default: begin i_sig = {1'b0, gen_cnt[12:0]}; q_sig = 14'd0 - {1'b0, gen_cnt[12:0]}; end
        endcase
    end

    function automatic logic [31:0] exp_ramp_entry(input int unsigned g);
        logic [13:0] iv, qv;
        iv = {1'b0, 13'(g)};
        qv = 14'd0 - iv;
        return {{2{qv[13]}}, qv, {2{iv[13]}}, iv};
    endfunction

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        addr = a; wdata = d; wen = 1'b1;
        @(posedge clk); #1;
        wen = 1'b0;
        last_gen = gen_cnt;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output logic k);
        addr = a; ren = 1'b1;
        @(posedge clk); #1;
        ren = 1'b0;
        d = rdata;
        k = ack;
    endtask

    task automatic wait_idle(input int max_cyc, output bit to);
        to = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(posedge clk); #1;
            if (!busy) begin to = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        logic [15:0] addrs [11] = '{16'h0100, 16'h010C, 16'h0104, 16'h0108, 16'h0114, 16'h0118,
                                    16'h0200, 16'h0204, 16'h0208, 16'h01FC, 16'h0300};
        logic [31:0] exps  [11] = '{32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                    32'd14, 32'd16, 32'd10, 32'h0, 32'h0};
        logic [31:0] d;
        logic        k;
        rstn = 1'b0; trig = 1'b0; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0;
        mode = 0; c_i = '0; c_q = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, ack, rdata} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b ack=%b rdata=%h want 0/0/0", busy, ack, rdata);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 11; n++) begin
            bus_read(addrs[n], d, k);
            n_cmp++;
            if (d !== exps[n] || k !== 1'b1) begin
                n_err++;
                $display("FAIL reset_reg addr=%h: got %h ack=%b want %h ack=1", addrs[n], d, k, exps[n]);
            end
        end
    endtask

    task automatic test_const_avg();
        logic [31:0] d, e;
        logic        k;
        bit          to;
        mode = 0; c_i = 14'sd100; c_q = -14'sd100;
        bus_write(16'h0104, 32'd2);
        bus_write(16'h0108, 32'd4);
        bus_write(16'h0100, 32'h1);
        repeat (4) exp_q.push_back(32'hFF9C_0064);
        addr = 16'h010C; ren = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (rdata !== ((c == 5) ? 32'd1 : 32'd0)) begin
                n_err++;
                $display("FAIL const_first_push cyc=%0d: got level %0d want %0d", c, rdata, (c == 5) ? 1 : 0);
            end
        end
        ren = 1'b0;
        wait_idle(64, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL const_idle: got busy=1 want busy=0 after ncap"); end
        bus_read(16'h010C, d, k);
        n_cmp++;
        if (d !== 32'd4) begin n_err++; $display("FAIL const_level: got %0d want 4", d); end
        bus_read(16'h0114, d, k);
        n_cmp++;
        if (d !== 32'd4) begin n_err++; $display("FAIL const_captured: got %0d want 4", d); end
        while (exp_q.size() > 0) begin
            bus_read(16'h0110, d, k);
            e = exp_q.pop_front();
            n_cmp++;
            if (d !== e) begin n_err++; $display("FAIL const_data: got %h want %h", d, e); end
        end
        bus_read(16'h0110, d, k);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL const_empty_read: got %h want 0", d); end
        bus_read(16'h0100, d, k);
        n_cmp++;
        if (d !== 32'h4) begin n_err++; $display("FAIL const_status: got %h want 4", d); end
    endtask

    task automatic test_floor();
        logic [31:0] d, e;
        logic        k;
        bit          to;
        mode = 1;
        bus_write(16'h0104, 32'd3);
        bus_write(16'h0108, 32'd3);
        bus_write(16'h0100, 32'h1);
        repeat (3) exp_q.push_back(32'hFFFC_0003);
        wait_idle(200, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL ramp_idle: got busy=1 want busy=0"); end
        while (exp_q.size() > 0) begin
            bus_read(16'h0110, d, k);
            e = exp_q.pop_front();
            n_cmp++;
            if (d !== e) begin n_err++; $display("FAIL ramp_data: got %h want %h", d, e); end
        end
        mode = 2;
        bus_write(16'h0104, 32'd1);
        bus_write(16'h0108, 32'd4);
        bus_write(16'h0100, 32'h1);
        repeat (4) exp_q.push_back(32'h0003_FFFC);
        wait_idle(200, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL alt_idle: got busy=1 want busy=0"); end
        while (exp_q.size() > 0) begin
            bus_read(16'h0110, d, k);
            e = exp_q.pop_front();
            n_cmp++;
            if (d !== e) begin n_err++; $display("FAIL alt_data: got %h want %h", d, e); end
        end
    endtask

    task automatic test_dec_sat();
        logic [31:0] d;
        logic        k;
        bus_write(16'h0104, 32'd40);
        bus_read(16'h0104, d, k);
        n_cmp++;
        if (d !== 32'd16) begin n_err++; $display("FAIL dec_saturate: got %0d want 16", d); end
        bus_write(16'h0104, 32'd7);
        bus_read(16'h0104, d, k);
        n_cmp++;
        if (d !== 32'd7) begin n_err++; $display("FAIL dec_readback: got %0d want 7", d); end
    endtask

    task automatic test_trigger();
        logic [31:0] d, e;
        logic        k;
        bit          to;
        mode = 0; c_i = 14'sd5; c_q = -14'sd7; trig = 1'b0;
        bus_write(16'h0104, 32'd2);
        bus_write(16'h0108, 32'd2);
        bus_write(16'h0100, 32'h3);
        repeat (50) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL trig_busy: got %b want 1", busy); end
        bus_read(16'h0100, d, k);
        n_cmp++;
        if (d !== 32'h107) begin n_err++; $display("FAIL trig_status: got %h want 107", d); end
        bus_read(16'h010C, d, k);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL trig_no_push: got level %0d want 0", d); end
        trig = 1'b1;
        repeat (2) exp_q.push_back(32'hFFF9_0005);
        wait_idle(64, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL trig_idle: got busy=1 want busy=0"); end
        trig = 1'b0;
        while (exp_q.size() > 0) begin
            bus_read(16'h0110, d, k);
            e = exp_q.pop_front();
            n_cmp++;
            if (d !== e) begin n_err++; $display("FAIL trig_data: got %h want %h", d, e); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        logic        k;
        bit          to;
        mode = 0; c_i = 14'sd1; c_q = 14'sd2;
        bus_write(16'h0104, 32'd0);
        bus_write(16'h0108, 32'd1);
        bus_write(16'h0100, 32'h1);
        wait_idle(16, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL abort_setup_idle: got busy=1 want busy=0"); end
        bus_write(16'h0100, 32'h5);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL abort_start_busy: got %b want 0", busy); end
        bus_read(16'h010C, d, k);
        n_cmp++;
        if (d !== 32'd1) begin n_err++; $display("FAIL abort_start_noflush: got level %0d want 1", d); end
        bus_write(16'h0108, 32'd0);
        bus_write(16'h0100, 32'h1);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL abort_run_busy: got %b want 1", busy); end
        repeat (5) @(posedge clk);
        #1;
        bus_write(16'h0100, 32'h4);
        bus_read(16'h0100, d, k);
        n_cmp++;
        if (d[9:8] !== 2'd0 || d[0] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_run_state: got state=%0d busy=%b want 0/0", d[9:8], d[0]);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d, e;
        logic        k;
        mode = 3;
        bus_write(16'h0104, 32'd0);
        bus_write(16'h0108, 32'd0);
        bus_write(16'h0100, 32'h1);
        for (int n = 0; n < 1024; n++) exp_q.push_back(exp_ramp_entry(last_gen + n));
        repeat (1100) @(posedge clk);
        #1;
        bus_write(16'h0100, 32'h4);
        bus_read(16'h0100, d, k);
        n_cmp++;
        if (d !== 32'h18) begin n_err++; $display("FAIL ovf_status: got %h want 18", d); end
        bus_read(16'h010C, d, k);
        n_cmp++;
        if (d !== 32'd1024) begin n_err++; $display("FAIL ovf_level: got %0d want 1024", d); end
        while (exp_q.size() > 0) begin
            bus_read(16'h0110, d, k);
            e = exp_q.pop_front();
            n_cmp++;
            if (d !== e) begin n_err++; $display("FAIL ovf_data: got %h want %h", d, e); end
        end
        bus_read(16'h0100, d, k);
        n_cmp++;
        if (d !== 32'h14) begin n_err++; $display("FAIL ovf_sticky: got %h want 14", d); end
    endtask

    task automatic test_full_pop();
        logic [31:0] d, e;
        logic        k;
        bit          to;
        mode = 3;
        bus_write(16'h0104, 32'd0);
        bus_write(16'h0108, 32'd1025);
        bus_write(16'h0100, 32'h1);
        for (int n = 0; n < 1025; n++) exp_q.push_back(exp_ramp_entry(last_gen + n));
        repeat (1024) @(posedge clk);
        #1;
        addr = 16'h0110; ren = 1'b1;
        @(posedge clk); #1;
        ren = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (rdata !== e) begin n_err++; $display("FAIL fullpop_head: got %h want %h", rdata, e); end
        wait_idle(16, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL fullpop_idle: got busy=1 want busy=0"); end
        bus_read(16'h0100, d, k);
        n_cmp++;
        if (d !== 32'h08) begin n_err++; $display("FAIL fullpop_status: got %h want 08", d); end
        bus_read(16'h010C, d, k);
        n_cmp++;
        if (d !== 32'd1024) begin n_err++; $display("FAIL fullpop_level: got %0d want 1024", d); end
        bus_read(16'h0114, d, k);
        n_cmp++;
        if (d !== 32'd1025) begin n_err++; $display("FAIL fullpop_captured: got %0d want 1025", d); end
        while (exp_q.size() > 0) begin
            bus_read(16'h0110, d, k);
            e = exp_q.pop_front();
            n_cmp++;
            if (d !== e) begin n_err++; $display("FAIL fullpop_data: got %h want %h", d, e); end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] d;
        logic        k;
        mode = 0; c_i = 14'sd9; c_q = 14'sd9;
        bus_write(16'h0104, 32'd0);
        bus_write(16'h0108, 32'd0);
        bus_write(16'h0100, 32'h1);
        repeat (10) @(posedge clk);
        #1;
        bus_read(16'h0100, d, k);
        n_cmp++;
        if (d[9:8] !== 2'd2) begin n_err++; $display("FAIL midrun_state: got %0d want 2", d[9:8]); end
        rstn = 1'b0;
        #2;
        n_cmp++;
        if ({busy, ack, rdata} !== 34'h0) begin
            n_err++;
            $display("FAIL midrun_async: got busy=%b ack=%b rdata=%h want 0/0/0", busy, ack, rdata);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        bus_read(16'h0100, d, k);
        n_cmp++;
        if (d !== 32'h4) begin n_err++; $display("FAIL midrun_status: got %h want 4", d); end
        bus_read(16'h010C, d, k);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL midrun_level: got %0d want 0", d); end
        bus_read(16'h0114, d, k);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL midrun_captured: got %0d want 0", d); end
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: got no finish want finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_const_avg();
        test_floor();
        test_dec_sat();
        test_trigger();
        test_abort();
        test_overflow();
        test_full_pop();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
